// File: rtl/bsg_mcl_slot_bridge_pkg.sv
// Shared types and helpers for the manycore <-> AXI-Lite slot bridge.
package bsg_mcl_slot_bridge_pkg;

    typedef enum logic {
        TX_FILL = 1'b0,
        TX_FULL = 1'b1
    } tx_state_e;

    // Host words needed to carry one manycore packet (tail word padded).
    function automatic int words_f(input int mc_width, input int axil_width);
        return (mc_width + axil_width - 1) / axil_width;
    endfunction

endpackage

// File: rtl/bsg_mcl_slot_bridge_channel.sv
// One bridge slot: receive packet FIFO + word serialiser, and transmit word
// deserialiser with flush/drop counting.
module bsg_mcl_slot_bridge_channel
    import bsg_mcl_slot_bridge_pkg::*;
#(
    parameter int mc_data_width_p    = 128,
    parameter int axil_data_width_p  = 32,
    parameter int rcv_fifo_els_p     = 256,
    parameter int drop_cnt_width_p   = 8,
    localparam int words_lp          = words_f(mc_data_width_p, axil_data_width_p),
    localparam int word_cnt_width_lp = $clog2(words_lp + 1),
    localparam int vac_width_lp      = $clog2(rcv_fifo_els_p + 1)
)(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         mc_v_i,
    input  logic [mc_data_width_p-1:0]   mc_data_i,
    output logic                         mc_ready_o,
    output logic                         host_v_o,
    output logic [axil_data_width_p-1:0] host_data_o,
    input  logic                         host_yumi_i,
    input  logic                         host_v_i,
    input  logic [axil_data_width_p-1:0] host_data_i,
    output logic                         host_ready_o,
    output logic                         mc_v_o,
    output logic [mc_data_width_p-1:0]   mc_data_o,
    input  logic                         mc_yumi_i,
    input  logic                         flush_i,
    output logic [vac_width_lp-1:0]      rcv_vacancy_o,
    output logic [drop_cnt_width_p-1:0]  tx_drop_cnt_o
);

    localparam int pad_width_lp = words_lp * axil_data_width_p;
    localparam int idx_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int ptr_width_lp = $clog2(rcv_fifo_els_p);
    localparam logic [idx_width_lp-1:0]      last_idx_lp = idx_width_lp'(words_lp - 1);
    localparam logic [word_cnt_width_lp-1:0] last_cnt_lp = word_cnt_width_lp'(words_lp - 1);
    localparam logic [ptr_width_lp-1:0]      last_ptr_lp = ptr_width_lp'(rcv_fifo_els_p - 1);
    localparam logic [vac_width_lp-1:0]      els_lp      = vac_width_lp'(rcv_fifo_els_p);

    logic [mc_data_width_p-1:0] rcv_mem [rcv_fifo_els_p];
    logic [ptr_width_lp-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [vac_width_lp-1:0]    vac_reg;
    logic [idx_width_lp-1:0]    rx_idx_reg;
    logic [pad_width_lp-1:0]    head_pad;
    logic                       enq, word_taken, deq;

    assign mc_ready_o    = (vac_reg != '0);
    assign host_v_o      = (vac_reg != els_lp);
    assign rcv_vacancy_o = vac_reg;
    assign enq           = mc_v_i & mc_ready_o;
    assign word_taken    = host_yumi_i & host_v_o;
    assign deq           = word_taken & (rx_idx_reg == last_idx_lp);

    // Head is read in place; zero-extension supplies the tail-word padding.
    assign head_pad    = pad_width_lp'(rcv_mem[rd_ptr_reg]);
    assign host_data_o = head_pad[rx_idx_reg * axil_data_width_p +: axil_data_width_p];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            rcv_mem[wr_ptr_reg] <= mc_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            vac_reg    <= els_lp;
            rx_idx_reg <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= (wr_ptr_reg == last_ptr_lp) ? '0 : wr_ptr_reg + ptr_width_lp'(1);
            end
            if (word_taken) begin
                rx_idx_reg <= deq ? '0 : rx_idx_reg + idx_width_lp'(1);
            end
            if (deq) begin
                rd_ptr_reg <= (rd_ptr_reg == last_ptr_lp) ? '0 : rd_ptr_reg + ptr_width_lp'(1);
            end
            case ({enq, deq})
                2'b10:   vac_reg <= vac_reg - vac_width_lp'(1);
                2'b01:   vac_reg <= vac_reg + vac_width_lp'(1);
                default: vac_reg <= vac_reg;
            endcase
        end
    end

    tx_state_e                     tx_state_reg;
    logic [word_cnt_width_lp-1:0]  tx_cnt_reg;
    logic [drop_cnt_width_p-1:0]   drop_reg;
    logic [axil_data_width_p-1:0]  tx_buf [words_lp];
    logic [pad_width_lp-1:0]       tx_flat;
    logic                          tx_flush, tx_accept;

    assign host_ready_o  = (tx_state_reg == TX_FILL);
    assign mc_v_o        = (tx_state_reg == TX_FULL);
    assign tx_drop_cnt_o = drop_reg;
    // A flush of a non-empty partial packet takes priority over a same-cycle word.
    assign tx_flush      = host_ready_o & flush_i & (tx_cnt_reg != '0);
    assign tx_accept     = host_ready_o & host_v_i & ~tx_flush;

    genvar gi;
    generate
        for (gi = 0; gi < words_lp; gi++) begin : g_tx_word
            assign tx_flat[gi*axil_data_width_p +: axil_data_width_p] = tx_buf[gi];
        end
    endgenerate

    assign mc_data_o = tx_flat[mc_data_width_p-1:0];

    always_ff @(posedge clk_i) begin
        if (tx_accept) begin
            tx_buf[tx_cnt_reg[idx_width_lp-1:0]] <= host_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_reg <= TX_FILL;
            tx_cnt_reg   <= '0;
            drop_reg     <= '0;
        end else begin
            case (tx_state_reg)
                TX_FILL: begin
                    if (tx_flush) begin
                        tx_cnt_reg <= '0;
                        if (drop_reg != '1) begin
                            drop_reg <= drop_reg + drop_cnt_width_p'(1);
                        end
                    end else if (tx_accept) begin
                        tx_cnt_reg <= tx_cnt_reg + word_cnt_width_lp'(1);
                        if (tx_cnt_reg == last_cnt_lp) begin
                            tx_state_reg <= TX_FULL;
                        end
                    end
                end
                TX_FULL: begin
                    if (mc_yumi_i) begin
                        tx_state_reg <= TX_FILL;
                        tx_cnt_reg   <= '0;
                    end
                end
                default: tx_state_reg <= TX_FILL;
            endcase
        end
    end

endmodule

// File: rtl/bsg_mcl_slot_bridge.sv
// Multi-slot bridge between manycore packet FIFOs and AXI-Lite word FIFOs;
// each slot is an independent channel, ports are flattened per slot.
module bsg_mcl_slot_bridge
    import bsg_mcl_slot_bridge_pkg::*;
#(
    parameter int num_slots_p       = 2,
    parameter int mc_data_width_p   = 128,
    parameter int axil_data_width_p = 32,
    parameter int rcv_fifo_els_p    = 256,
    parameter int drop_cnt_width_p  = 8,
    localparam int vac_width_lp     = $clog2(rcv_fifo_els_p + 1)
)(
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_slots_p-1:0]                   mc_v_i,
    input  logic [num_slots_p*mc_data_width_p-1:0]   mc_data_i,
    output logic [num_slots_p-1:0]                   mc_ready_o,
    output logic [num_slots_p-1:0]                   host_v_o,
    output logic [num_slots_p*axil_data_width_p-1:0] host_data_o,
    input  logic [num_slots_p-1:0]                   host_yumi_i,
    input  logic [num_slots_p-1:0]                   host_v_i,
    input  logic [num_slots_p*axil_data_width_p-1:0] host_data_i,
    output logic [num_slots_p-1:0]                   host_ready_o,
    output logic [num_slots_p-1:0]                   mc_v_o,
    output logic [num_slots_p*mc_data_width_p-1:0]   mc_data_o,
    input  logic [num_slots_p-1:0]                   mc_yumi_i,
    input  logic [num_slots_p-1:0]                   flush_i,
    output logic [num_slots_p*vac_width_lp-1:0]      rcv_vacancy_o,
    output logic [num_slots_p*drop_cnt_width_p-1:0]  tx_drop_cnt_o
);

    genvar gi;
    generate
        for (gi = 0; gi < num_slots_p; gi++) begin : g_slot
            bsg_mcl_slot_bridge_channel #(
                .mc_data_width_p  (mc_data_width_p),
                .axil_data_width_p(axil_data_width_p),
                .rcv_fifo_els_p   (rcv_fifo_els_p),
                .drop_cnt_width_p (drop_cnt_width_p)
            ) channel (
                .clk_i        (clk_i),
                .reset_i      (reset_i),
                .mc_v_i       (mc_v_i[gi]),
                .mc_data_i    (mc_data_i[gi*mc_data_width_p +: mc_data_width_p]),
                .mc_ready_o   (mc_ready_o[gi]),
                .host_v_o     (host_v_o[gi]),
                .host_data_o  (host_data_o[gi*axil_data_width_p +: axil_data_width_p]),
                .host_yumi_i  (host_yumi_i[gi]),
                .host_v_i     (host_v_i[gi]),
                .host_data_i  (host_data_i[gi*axil_data_width_p +: axil_data_width_p]),
                .host_ready_o (host_ready_o[gi]),
                .mc_v_o       (mc_v_o[gi]),
                .mc_data_o    (mc_data_o[gi*mc_data_width_p +: mc_data_width_p]),
                .mc_yumi_i    (mc_yumi_i[gi]),
                .flush_i      (flush_i[gi]),
                .rcv_vacancy_o(rcv_vacancy_o[gi*vac_width_lp +: vac_width_lp]),
                .tx_drop_cnt_o(tx_drop_cnt_o[gi*drop_cnt_width_p +: drop_cnt_width_p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bsg_mcl_slot_bridge.sv
// Directed bench: dut_a is 128/32 with 256-deep receive, dut_b is 100/32 with 2-deep receive.
module tb_bsg_mcl_slot_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b;
    logic [1:0]   a_mc_v, a_mc_ready, a_host_v, a_yumi, a_hv_i, a_hready, a_mcv_o, a_mc_yumi, a_flush;
    logic [255:0] a_mc_data_i, a_mc_data_o;
    logic [63:0]  a_hdata_o, a_hdata_i;
    logic [17:0]  a_vac;
    logic [15:0]  a_drop;

    logic [1:0]   b_mc_v, b_mc_ready, b_host_v, b_yumi, b_hv_i, b_hready, b_mcv_o, b_mc_yumi, b_flush;
    logic [199:0] b_mc_data_i, b_mc_data_o;
    logic [63:0]  b_hdata_o, b_hdata_i;
    logic [3:0]   b_vac;
    logic [15:0]  b_drop;

    bsg_mcl_slot_bridge #(.num_slots_p(2), .mc_data_width_p(128), .axil_data_width_p(32),
                          .rcv_fifo_els_p(256), .drop_cnt_width_p(8)) dut_a (
        .clk_i(clk), .reset_i(rst_a),
        .mc_v_i(a_mc_v), .mc_data_i(a_mc_data_i), .mc_ready_o(a_mc_ready),
        .host_v_o(a_host_v), .host_data_o(a_hdata_o), .host_yumi_i(a_yumi),
        .host_v_i(a_hv_i), .host_data_i(a_hdata_i), .host_ready_o(a_hready),
        .mc_v_o(a_mcv_o), .mc_data_o(a_mc_data_o), .mc_yumi_i(a_mc_yumi),
        .flush_i(a_flush), .rcv_vacancy_o(a_vac), .tx_drop_cnt_o(a_drop));

    bsg_mcl_slot_bridge #(.num_slots_p(2), .mc_data_width_p(100), .axil_data_width_p(32),
                          .rcv_fifo_els_p(2), .drop_cnt_width_p(8)) dut_b (
        .clk_i(clk), .reset_i(rst_b),
        .mc_v_i(b_mc_v), .mc_data_i(b_mc_data_i), .mc_ready_o(b_mc_ready),
        .host_v_o(b_host_v), .host_data_o(b_hdata_o), .host_yumi_i(b_yumi),
        .host_v_i(b_hv_i), .host_data_i(b_hdata_i), .host_ready_o(b_hready),
        .mc_v_o(b_mcv_o), .mc_data_o(b_mc_data_o), .mc_yumi_i(b_mc_yumi),
        .flush_i(b_flush), .rcv_vacancy_o(b_vac), .tx_drop_cnt_o(b_drop));

    typedef struct {
        logic mc_v; logic [127:0] mc_data; logic yumi;
        logic hv; logic [31:0] hdata; logic flush; logic mc_yumi;
        logic e_hv; logic [31:0] e_hdata; logic e_rdy; int e_vac;
        logic e_hrdy; logic e_mcv; logic [127:0] e_mcdata; int e_drop;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic mc_v, logic [127:0] mc_data, logic yumi,
                                logic hv, logic [31:0] hdata, logic flush, logic mc_yumi,
                                logic e_hv, logic [31:0] e_hdata, logic e_rdy, int e_vac,
                                logic e_hrdy, logic e_mcv, logic [127:0] e_mcdata, int e_drop);
        vec_t v;
        v.mc_v = mc_v; v.mc_data = mc_data; v.yumi = yumi;
        v.hv = hv; v.hdata = hdata; v.flush = flush; v.mc_yumi = mc_yumi;
        v.e_hv = e_hv; v.e_hdata = e_hdata; v.e_rdy = e_rdy; v.e_vac = e_vac;
        v.e_hrdy = e_hrdy; v.e_mcv = e_mcv; v.e_mcdata = e_mcdata; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_a_reset(input int s);
        chk($sformatf("a%0d rst mc_ready", s), a_mc_ready[s], 1'b1);
        chk($sformatf("a%0d rst host_v", s), a_host_v[s], 1'b0);
        chk($sformatf("a%0d rst host_ready", s), a_hready[s], 1'b1);
        chk($sformatf("a%0d rst mc_v", s), a_mcv_o[s], 1'b0);
        chk($sformatf("a%0d rst vacancy", s), a_vac[s*9 +: 9], 256);
        chk($sformatf("a%0d rst drop", s), a_drop[s*8 +: 8], 0);
    endtask

    localparam logic [127:0] P  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] T1 = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] T2 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] P2 = 128'h000000B3_000000B2_000000B1_000000B0;
    localparam logic [127:0] P3 = 128'h000000C3_000000C2_000000C1_000000C0;
    localparam logic [127:0] P4 = 128'h000000D3_000000D2_000000D1_000000D0;
    localparam logic [127:0] S1 = 128'h000000E3_000000E2_000000E1_000000E0;
    localparam logic [127:0] T3 = 128'h00000064_00000063_00000062_00000061;

    initial begin
        logic [99:0]  ones100;
        logic [99:0]  q100;
        logic [31:0]  q_words [4];
        ones100 = '1;
        q100    = 100'h5_66666666_77777777_88888888;
        q_words[0] = 32'h88888888; q_words[1] = 32'h77777777;
        q_words[2] = 32'h66666666; q_words[3] = 32'h00000005;

        rst_a = 1'b1; rst_b = 1'b1;
        a_mc_v = '0; a_mc_data_i = '0; a_yumi = '0; a_hv_i = '0; a_hdata_i = '0; a_mc_yumi = '0; a_flush = '0;
        b_mc_v = '0; b_mc_data_i = '0; b_yumi = '0; b_hv_i = '0; b_hdata_i = '0; b_mc_yumi = '0; b_flush = '0;
        step();
        step();
        rst_a = 1'b0; rst_b = 1'b0;

        //         mc_v data yumi hv hdata    fl my  e_hv e_hdata      rdy vac  hrdy mcv mcdata drop
        tbl.push_back(mk(1, P,  0, 0, 32'h0,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  1, 0, 32'h0,  0, 0, 1, 32'h11111111, 1, 255, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  1, 0, 32'h0,  0, 0, 1, 32'h22222222, 1, 255, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  1, 0, 32'h0,  0, 0, 1, 32'h33333333, 1, 255, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  1, 0, 32'h0,  0, 0, 1, 32'h44444444, 1, 255, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  0, 1, 32'h1,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  0, 1, 32'h2,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,  1, 0, 0, 32'h0,        1, 256, 1, 0, 0,  0));
        tbl.push_back(mk(0, 0,  0, 1, 32'hA,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'hB,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'hC,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'hD,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,  1, 0, 0, 32'h0,        1, 256, 0, 1, T1, 1));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,  0, 1, 0, 32'h0,        1, 256, 0, 1, T1, 1));
        tbl.push_back(mk(0, 0,  0, 1, 32'hE,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'hF,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'h10, 0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'h99, 1, 0, 0, 32'h0,        1, 256, 1, 0, 0,  1));
        tbl.push_back(mk(0, 0,  0, 1, 32'h1,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  0, 1, 32'h2,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  0, 1, 32'h3,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  0, 1, 32'h4,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,  0, 1, 0, 32'h0,        1, 256, 0, 1, T2, 2));
        tbl.push_back(mk(1, P2, 0, 0, 32'h0,  0, 0, 0, 32'h0,        1, 256, 1, 0, 0,  2));
        tbl.push_back(mk(1, P3, 1, 0, 32'h0,  0, 0, 1, 32'hB0,       1, 255, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  1, 0, 32'h0,  0, 0, 1, 32'hB1,       1, 254, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  1, 0, 32'h0,  0, 0, 1, 32'hB2,       1, 254, 1, 0, 0,  2));
        tbl.push_back(mk(1, P4, 1, 0, 32'h0,  0, 0, 1, 32'hB3,       1, 254, 1, 0, 0,  2));
        tbl.push_back(mk(0, 0,  0, 0, 32'h0,  0, 0, 1, 32'hC0,       1, 254, 1, 0, 0,  2));

        for (int i = 0; i < tbl.size(); i++) begin
            a_mc_v[0] = tbl[i].mc_v; a_mc_data_i[127:0] = tbl[i].mc_data; a_yumi[0] = tbl[i].yumi;
            a_hv_i[0] = tbl[i].hv; a_hdata_i[31:0] = tbl[i].hdata;
            a_flush[0] = tbl[i].flush; a_mc_yumi[0] = tbl[i].mc_yumi;
            chk($sformatf("v%0d host_v", i), a_host_v[0], tbl[i].e_hv);
            if (tbl[i].e_hv) chk($sformatf("v%0d host_data", i), a_hdata_o[31:0], tbl[i].e_hdata);
            chk($sformatf("v%0d mc_ready", i), a_mc_ready[0], tbl[i].e_rdy);
            chk($sformatf("v%0d vacancy", i), a_vac[8:0], tbl[i].e_vac);
            chk($sformatf("v%0d host_ready", i), a_hready[0], tbl[i].e_hrdy);
            chk($sformatf("v%0d mc_v", i), a_mcv_o[0], tbl[i].e_mcv);
            if (tbl[i].e_mcv) chk($sformatf("v%0d mc_data", i), a_mc_data_o[127:0], tbl[i].e_mcdata);
            chk($sformatf("v%0d drop", i), a_drop[7:0], tbl[i].e_drop);
            $display("vec %0d applied: mc_v=%0b yumi=%0b hv=%0b flush=%0b mc_yumi=%0b",
                     i, tbl[i].mc_v, tbl[i].yumi, tbl[i].hv, tbl[i].flush, tbl[i].mc_yumi);
            step();
        end
        a_mc_v = '0; a_yumi = '0; a_hv_i = '0; a_flush = '0; a_mc_yumi = '0;

        // slot 1 stayed idle through all slot 0 traffic
        chk("a1 idle host_v", a_host_v[1], 1'b0);
        chk("a1 idle vacancy", a_vac[17:9], 256);
        chk("a1 idle mc_v", a_mcv_o[1], 1'b0);

        // Reset with partial tx and half-read rx on slot 0, slot 1 busy alongside.
        a_hv_i[0] = 1'b1; a_hdata_i[31:0] = 32'h51; a_yumi[0] = 1'b1;
        a_mc_v[1] = 1'b1; a_mc_data_i[255:128] = S1;
        step();
        a_yumi[0] = 1'b0; a_mc_v[1] = 1'b0; a_hdata_i[31:0] = 32'h52;
        chk("a0 half-read data", a_hdata_o[31:0], 32'hC1);
        chk("a1 word0 data", a_hdata_o[63:32], 32'hE0);
        chk("a1 vacancy", a_vac[17:9], 255);
        step();
        a_hv_i[0] = 1'b0; a_yumi[1] = 1'b1; rst_a = 1'b1;
        chk("a0 pre-reset vacancy", a_vac[8:0], 254);
        chk("a1 pre-reset host_v", a_host_v[1], 1'b1);
        step();
        rst_a = 1'b0; a_yumi[1] = 1'b0;
        chk_a_reset(0);
        chk_a_reset(1);
        for (int k = 0; k < 4; k++) begin
            a_hv_i[0] = 1'b1; a_hdata_i[31:0] = 32'h61 + k;
            step();
        end
        a_hv_i[0] = 1'b0;
        chk("a0 post-reset mc_v", a_mcv_o[0], 1'b1);
        chk("a0 post-reset mc_data", a_mc_data_o[127:0], T3);

        // 100-bit packets, 2-deep receive FIFO
        b_mc_v[0] = 1'b1; b_mc_data_i[99:0] = ones100;
        chk("b rst vacancy", b_vac[1:0], 2);
        step();
        b_mc_data_i[99:0] = q100;
        chk("b vac after 1", b_vac[1:0], 1);
        step();
        b_mc_v[0] = 1'b0;
        chk("b full mc_ready", b_mc_ready[0], 1'b0);
        chk("b full vacancy", b_vac[1:0], 0);
        for (int k = 0; k < 4; k++) begin
            b_yumi[0] = 1'b1;
            if (k == 3) begin
                b_mc_v[0] = 1'b1; b_mc_data_i[99:0] = 100'h123;
            end
            chk($sformatf("b ones w%0d", k), b_hdata_o[31:0], (k == 3) ? 32'h0000000F : 32'hFFFFFFFF);
            chk($sformatf("b ready w%0d", k), b_mc_ready[0], 1'b0);
            step();
        end
        b_mc_v[0] = 1'b0; b_yumi[0] = 1'b0;
        chk("b vac after deq", b_vac[1:0], 1);
        chk("b ready after deq", b_mc_ready[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            b_yumi[0] = 1'b1;
            chk($sformatf("b q w%0d", k), b_hdata_o[31:0], q_words[k]);
            step();
        end
        b_yumi[0] = 1'b0;
        chk("b drained host_v", b_host_v[0], 1'b0);
        chk("b drained vacancy", b_vac[1:0], 2);

        for (int k = 0; k < 4; k++) begin
            b_hv_i[0] = 1'b1; b_hdata_i[31:0] = 32'hFFFFFFFF;
            step();
        end
        b_hv_i[0] = 1'b0;
        chk("b tx mc_v", b_mcv_o[0], 1'b1);
        chk("b tx mc_data", b_mc_data_o[99:0], ones100);
        b_mc_yumi[0] = 1'b1;
        step();
        b_mc_yumi[0] = 1'b0;

        for (int k = 0; k < 300; k++) begin
            b_hv_i[0] = 1'b1; b_hdata_i[31:0] = k;
            step();
            b_flush[0] = 1'b1;
            step();
            b_flush[0] = 1'b0;
            if (k == 0) chk("b drop first", b_drop[7:0], 1);
        end
        b_hv_i[0] = 1'b0;
        chk("b drop saturated", b_drop[7:0], 255);
        chk("b host_ready after flushes", b_hready[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
